// File: rtl/mux_demux_pkg.sv
// Shared definitions for the N-channel time-shared mux/demux lane.
package mux_demux_pkg;

  localparam int unsigned MAX_CHANNELS = 64;

  // Channel tag width, never narrower than one bit.
  function automatic int unsigned tag_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: picks the first requester at or above the rotating pointer,
// with wrap. The pointer moves past the winner only when a grant is issued.
module rr_arbiter_n
  import mux_demux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned TAG_W = tag_w(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic [CHANNELS-1:0] req,
  output logic [CHANNELS-1:0] grant,
  output logic [TAG_W-1:0]    idx
);

  localparam logic [TAG_W-1:0] LastCh = TAG_W'(CHANNELS - 1);

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic             found;

  always_comb begin
    int unsigned c;
    c     = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      c = 32'(ptr_q) + k;
      if (c >= CHANNELS) c = c - CHANNELS;
      if (!found && req[c[TAG_W-1:0]]) begin
        found = 1'b1;
        idx   = c[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    if (en && found) begin
      grant[idx] = 1'b1;
      // Explicit wrap keeps non-power-of-two channel counts in range.
      ptr_d      = (idx == LastCh) ? '0 : idx + TAG_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_to_demux_n.sv
// CHANNELS producers share one pipelined WIDTH-bit lane; each word carries its channel
// tag through STAGES registers and is delivered on the output port with the same index.
module mux_to_demux_n
  import mux_demux_pkg::*;
#(
  parameter int          ID       = 1,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned STAGES   = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [CHANNELS-1:0][WIDTH-1:0]     in_data,
  input  logic [CHANNELS-1:0]                in_valid,
  output logic [CHANNELS-1:0]                in_ready,
  output logic [CHANNELS-1:0][WIDTH-1:0]     out_data,
  output logic [CHANNELS-1:0]                out_valid,
  input  logic [CHANNELS-1:0]                out_ready,
  output logic                               busy
);

  localparam int unsigned TAG_W = tag_w(CHANNELS);

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } lane_stage_t;

  if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS || STAGES < 1 || ID < 0) begin : g_bad_param
    $error("mux_to_demux_n: illegal parameterisation");
  end

  (* keep = "true" *) lane_stage_t [STAGES-1:0] lane_q;
  lane_stage_t [STAGES-1:0] lane_in;
  lane_stage_t              head;
  lane_stage_t              stage0_d;
  logic [STAGES-1:0]        stage_v;
  logic [TAG_W-1:0]         win_idx;
  logic                     advance;
  logic                     transfer;

  assign head    = lane_q[STAGES-1];
  // Global stall: the whole lane holds while the head waits for its consumer.
  assign advance = !head.v || out_ready[head.tag];

  (* keep = "true" *) rr_arbiter_n #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .clock (clock),
    .reset (reset),
    .en    (advance && !reset),
    .req   (in_valid),
    .grant (in_ready),
    .idx   (win_idx)
  );

  assign transfer = |in_ready;

  // Bubbles are zeroed so an idle head never leaks stale data onto out_data.
  always_comb begin
    stage0_d = '0;
    if (transfer) begin
      stage0_d.v    = 1'b1;
      stage0_d.tag  = win_idx;
      stage0_d.data = in_data[win_idx];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_lane
    if (k == 0) begin : g_first
      assign lane_in[k] = stage0_d;
    end else begin : g_shift
      assign lane_in[k] = lane_q[k-1];
    end
    assign stage_v[k] = lane_q[k].v;
  end

  always_ff @(posedge clock) begin
    if (reset)        lane_q <= '0;
    else if (advance) lane_q <= lane_in;
  end

  assign busy = |stage_v;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_out
    assign out_valid[c] = head.v && (head.tag == TAG_W'(c));
    assign out_data[c]  = (head.tag == TAG_W'(c)) ? head.data : '0;
  end

endmodule

// File: tb/tb_mux_to_demux_n.sv
// Self-checking bench: directed scenarios on a 4-channel/2-stage lane and a random soak
// on a 3-channel/3-stage lane, both checked against a slot-list reference model.
module tb_mux_to_demux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 4-channel, 2-stage instance
  logic              rst4;
  logic [3:0][15:0]  id4;
  logic [3:0]        iv4, ir4, ov4, or4;
  logic [3:0][15:0]  od4;
  logic              busy4;

  // 3-channel, 3-stage instance
  logic              rst3;
  logic [2:0][15:0]  id3;
  logic [2:0]        iv3, ir3, ov3, or3;
  logic [2:0][15:0]  od3;
  logic              busy3;

  mux_to_demux_n #(.ID(1), .WIDTH(16), .CHANNELS(4), .STAGES(2)) dut4 (
    .clock(clk), .reset(rst4), .in_data(id4), .in_valid(iv4), .in_ready(ir4),
    .out_data(od4), .out_valid(ov4), .out_ready(or4), .busy(busy4)
  );

  mux_to_demux_n #(.ID(2), .WIDTH(16), .CHANNELS(3), .STAGES(3)) dut3 (
    .clock(clk), .reset(rst3), .in_data(id3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_valid(ov3), .out_ready(or3), .busy(busy3)
  );

  // Reference model: per instance, a list of lane slots (index ns-1 is the head).
  int          mptr [2];
  logic        mv   [2][4];
  int          mtag [2][4];
  logic [15:0] mdat [2][4];

  function automatic int pick(int m, int nc, logic [3:0] req);
    for (int k = 0; k < nc; k++) begin
      if (req[(mptr[m] + k) % nc]) return (mptr[m] + k) % nc;
    end
    return -1;
  endfunction

  // Expected {in_ready, out_valid, busy, out_data} for the current inputs.
  function automatic logic [72:0] expect_vec(int m, int nc, int ns, logic rst,
                                             logic [3:0] req, logic [3:0] ordy);
    logic [3:0]       rdy, ov;
    logic             bsy, adv;
    logic [3:0][15:0] od;
    int               w;
    rdy = '0; ov = '0; bsy = 1'b0; od = '0;
    adv = !mv[m][ns-1] || ordy[mtag[m][ns-1]];
    w   = pick(m, nc, req);
    if (!rst && adv && w >= 0) rdy[w] = 1'b1;
    if (mv[m][ns-1]) begin
      ov[mtag[m][ns-1]] = 1'b1;
      od[mtag[m][ns-1]] = mdat[m][ns-1];
    end
    for (int k = 0; k < ns; k++) bsy = bsy | mv[m][k];
    return {rdy, ov, bsy, od};
  endfunction

  task automatic model_clock(int m, int nc, int ns, logic rst, logic [3:0] req,
                             logic [3:0][15:0] din, logic [3:0] ordy);
    int   w;
    logic adv;
    if (rst) begin
      mptr[m] = 0;
      for (int k = 0; k < 4; k++) begin
        mv[m][k] = 1'b0; mtag[m][k] = 0; mdat[m][k] = '0;
      end
      return;
    end
    adv = !mv[m][ns-1] || ordy[mtag[m][ns-1]];
    if (!adv) return;
    w = pick(m, nc, req);
    for (int k = ns - 1; k > 0; k--) begin
      mv[m][k] = mv[m][k-1]; mtag[m][k] = mtag[m][k-1]; mdat[m][k] = mdat[m][k-1];
    end
    mv[m][0] = 1'b0; mtag[m][0] = 0; mdat[m][0] = '0;
    if (w >= 0) begin
      mv[m][0] = 1'b1; mtag[m][0] = w; mdat[m][0] = din[w];
      mptr[m] = (w + 1) % nc;
    end
  endtask

  task automatic reset4();
    @(negedge clk);
    rst4 = 1'b1; iv4 = '0; or4 = 4'hF;
    #1 model_clock(0, 4, 2, rst4, iv4, id4, or4);
  endtask

  task automatic test_reset();
    rst4 = 1'b1; iv4 = 4'hF; or4 = 4'hF;
    for (int c = 0; c < 4; c++) id4[c] = 16'($urandom);
    model_clock(0, 4, 2, 1'b1, iv4, id4, or4);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({ir4, ov4, busy4, od4} !== 73'd0) begin
        n_bad++;
        $display("FAIL reset cyc%0d: got ready=%b valid=%b busy=%b data=%h want all zero",
                 i, ir4, ov4, busy4, od4);
      end
      model_clock(0, 4, 2, rst4, iv4, id4, or4);
    end
  endtask

  task automatic test_single();
    logic [72:0] exp_v;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      rst4 = 1'b0; or4 = 4'hF;
      iv4  = (s == 0) ? 4'b0100 : 4'b0000;
      if (s == 0) id4[2] = 16'hBEEF;
      #1;
      exp_v = expect_vec(0, 4, 2, rst4, iv4, or4);
      n_cmp++;
      if ({ir4, ov4, busy4, od4} !== exp_v) begin
        n_bad++;
        $display("FAIL single s%0d: got %h want %h", s, {ir4, ov4, busy4, od4}, exp_v);
      end
      if (s == 0) begin
        n_cmp++;
        if (ir4 !== 4'b0100) begin
          n_bad++; $display("FAIL single_grant: got %b want 0100", ir4);
        end
      end
      if (s == 2) begin
        n_cmp++;
        if (ov4 !== 4'b0100 || od4[2] !== 16'hBEEF) begin
          n_bad++;
          $display("FAIL single_out: got valid=%b data=%h want 0100/beef", ov4, od4[2]);
        end
      end
      model_clock(0, 4, 2, rst4, iv4, id4, or4);
    end
  endtask

  task automatic test_round_robin();
    logic [72:0] exp_v;
    logic [3:0]  prev_rdy;
    reset4();
    prev_rdy = '0;
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      rst4 = 1'b0; or4 = 4'hF;
      iv4  = (s < 12) ? 4'hF : 4'h0;
      for (int c = 0; c < 4; c++) if (prev_rdy[c]) id4[c] = 16'($urandom);
      #1;
      exp_v    = expect_vec(0, 4, 2, rst4, iv4, or4);
      prev_rdy = exp_v[72:69];
      n_cmp++;
      if ({ir4, ov4, busy4, od4} !== exp_v) begin
        n_bad++;
        $display("FAIL rr s%0d: got %h want %h", s, {ir4, ov4, busy4, od4}, exp_v);
      end
      if (s < 12) begin
        n_cmp++;
        if (ir4 !== (4'b0001 << (s % 4))) begin
          n_bad++; $display("FAIL rr_grant s%0d: got %b want %b", s, ir4, 4'b0001 << (s % 4));
        end
      end
      if (s >= 2 && s < 14) begin
        n_cmp++;
        if (ov4 !== (4'b0001 << ((s - 2) % 4))) begin
          n_bad++;
          $display("FAIL rr_order s%0d: got %b want %b", s, ov4, 4'b0001 << ((s - 2) % 4));
        end
      end
      model_clock(0, 4, 2, rst4, iv4, id4, or4);
    end
  endtask

  task automatic test_backpressure();
    logic [72:0] exp_v;
    logic [15:0] seen [$];
    logic [15:0] want [3];
    want[0] = 16'h1111; want[1] = 16'h3333; want[2] = 16'h0A0A;
    reset4();
    for (int s = 0; s < 11; s++) begin
      @(negedge clk);
      rst4 = 1'b0;
      or4  = (s >= 2 && s <= 6) ? 4'b1101 : 4'hF;
      if (s == 0)      begin iv4 = 4'b0010; id4[1] = 16'h1111; end
      else if (s == 1) begin iv4 = 4'b1001; id4[0] = 16'h0A0A; id4[3] = 16'h3333; end
      else if (s <= 7) iv4 = 4'b0001;
      else             iv4 = 4'b0000;
      #1;
      exp_v = expect_vec(0, 4, 2, rst4, iv4, or4);
      n_cmp++;
      if ({ir4, ov4, busy4, od4} !== exp_v) begin
        n_bad++;
        $display("FAIL bp s%0d: got %h want %h", s, {ir4, ov4, busy4, od4}, exp_v);
      end
      if (s >= 2 && s <= 6) begin
        n_cmp++;
        if (ir4 !== 4'b0000 || ov4 !== 4'b0010) begin
          n_bad++; $display("FAIL bp_stall s%0d: got ready=%b valid=%b want 0000/0010",
                            s, ir4, ov4);
        end
      end
      if (s == 7) begin
        n_cmp++;
        if (ir4 !== 4'b0001) begin
          n_bad++; $display("FAIL bp_release_grant: got %b want 0001", ir4);
        end
      end
      for (int c = 0; c < 4; c++) if (ov4[c] && or4[c]) seen.push_back(od4[c]);
      model_clock(0, 4, 2, rst4, iv4, id4, or4);
    end
    n_cmp++;
    if (seen.size() != 3 || seen[0] !== want[0] || seen[1] !== want[1] || seen[2] !== want[2])
    begin
      n_bad++;
      $display("FAIL bp_sequence: got %0d words (%p) want 1111,3333,0a0a", seen.size(), seen);
    end
  endtask

  task automatic test_reset_midflight();
    logic [72:0] exp_v;
    reset4();
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      rst4 = (s == 2);
      or4  = (s <= 2) ? 4'h0 : 4'hF;
      if (s == 0)      begin iv4 = 4'b0001; id4[0] = 16'h5555; end
      else if (s == 1) begin iv4 = 4'b0010; id4[1] = 16'h6666; end
      else             iv4 = 4'b0000;
      #1;
      exp_v = expect_vec(0, 4, 2, rst4, iv4, or4);
      n_cmp++;
      if ({ir4, ov4, busy4, od4} !== exp_v) begin
        n_bad++;
        $display("FAIL midrst s%0d: got %h want %h", s, {ir4, ov4, busy4, od4}, exp_v);
      end
      if (s == 2) begin
        n_cmp++;
        if (busy4 !== 1'b1) begin
          n_bad++; $display("FAIL midrst_loaded: got busy=%b want 1", busy4);
        end
      end
      if (s >= 3) begin
        n_cmp++;
        if (busy4 !== 1'b0 || ov4 !== 4'b0000) begin
          n_bad++; $display("FAIL midrst_flushed s%0d: got busy=%b valid=%b want 0/0000",
                            s, busy4, ov4);
        end
      end
      model_clock(0, 4, 2, rst4, iv4, id4, or4);
    end
  endtask

  task automatic test_soak();
    logic [72:0] exp_v, obs_v;
    logic [2:0]  prev_rdy;
    logic [17:0] sbq [$];
    logic [17:0] front;
    int          waitc [3];
    int          max_wait;
    prev_rdy = '0; max_wait = 0;
    for (int c = 0; c < 3; c++) waitc[c] = 0;
    iv3 = '0; or3 = 3'b111; id3 = '0;
    model_clock(1, 3, 3, 1'b1, 4'h0, '0, 4'h0);
    for (int s = 0; s < 10010; s++) begin
      @(negedge clk);
      rst3 = (s < 2);
      if (s >= 10000) begin
        iv3 = '0; or3 = 3'b111;
      end else begin
        for (int c = 0; c < 3; c++) begin
          if (!iv3[c] || prev_rdy[c]) begin
            iv3[c] = ($urandom_range(0, 1) == 1);
            id3[c] = 16'($urandom);
          end
          or3[c] = ($urandom_range(0, 3) != 0);
        end
      end
      #1;
      exp_v    = expect_vec(1, 3, 3, rst3, {1'b0, iv3}, {1'b0, or3});
      obs_v    = {1'b0, ir3, 1'b0, ov3, busy3, 16'h0, od3};
      prev_rdy = exp_v[71:69];
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL soak s%0d: got %h want %h", s, obs_v, exp_v);
      end
      for (int c = 0; c < 3; c++) begin
        if (ov3[c] && or3[c]) begin
          n_cmp++;
          if (sbq.size() == 0) begin
            n_bad++; $display("FAIL soak_sb s%0d: got ch%0d %h want nothing", s, c, od3[c]);
          end else begin
            front = sbq.pop_front();
            if ({2'(c), od3[c]} !== front) begin
              n_bad++; $display("FAIL soak_sb s%0d: got ch%0d %h want ch%0d %h",
                                s, c, od3[c], front[17:16], front[15:0]);
            end
          end
        end
      end
      for (int c = 0; c < 3; c++) if (exp_v[69 + c] && iv3[c]) sbq.push_back({2'(c), id3[c]});
      for (int c = 0; c < 3; c++) begin
        if (!rst3 && iv3[c]) begin
          if (ir3[c]) begin
            if (waitc[c] > max_wait) max_wait = waitc[c];
            waitc[c] = 0;
          end else if (|ir3) begin
            waitc[c]++;
          end
        end
      end
      model_clock(1, 3, 3, rst3, {1'b0, iv3}, {16'h0, id3}, {1'b0, or3});
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++; $display("FAIL soak_drain: got %0d words left want 0", sbq.size());
    end
    n_cmp++;
    if (max_wait > 2) begin
      n_bad++; $display("FAIL soak_fairness: got max wait %0d want <= 2", max_wait);
    end
  endtask

  initial begin
    rst3 = 1'b1; iv3 = '0; or3 = '0; id3 = '0;
    id4 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
